tdpram_port_master: RTL and testbench

//   Initiator side of one true-dual-port RAM port: accepts a valid/ready request stream (read or

---
 rtl/tdpram_port_master.sv | 124 ++++++++++++
 tb/tb_tdpram_port_master.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/tdpram_port_master.sv
// Initiator for one port of a true-dual-port RAM: registered RAM drive, read-latency
// tracking, and an in-order response FIFO guarded by read credits.
module tdpram_port_master #(
  parameter int ADDR_WIDTH       = 10,
  parameter int DATA_WIDTH       = 32,
  parameter int BYTE_WRITE_WIDTH = 8,
  parameter int READ_LATENCY     = 2,
  parameter int RSP_DEPTH        = 4,
  parameter int NB               = DATA_WIDTH / BYTE_WRITE_WIDTH
) (
  input  logic                  clka,
  input  logic                  rsta,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [NB-1:0]         req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  ena,
  output logic                  regcea,
  output logic [NB-1:0]         wea,
  output logic [ADDR_WIDTH-1:0] addra,
  output logic [DATA_WIDTH-1:0] dina,
  input  logic [DATA_WIDTH-1:0] douta
);

  localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CNT_W = $clog2(RSP_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(RSP_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(RSP_DEPTH - 1);

  logic [CNT_W-1:0]        credit_q, credit_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic                    ena_q, ena_d, regcea_q, regcea_d;
  logic [NB-1:0]           wea_q, wea_d;
  logic [ADDR_WIDTH-1:0]   addra_q, addra_d;
  logic [DATA_WIDTH-1:0]   dina_q, dina_d;
  logic [READ_LATENCY-1:0] lat_vld_q, lat_vld_d;
  logic [DATA_WIDTH-1:0]   fifo_mem_q [RSP_DEPTH];

  logic req_fire, rd_fire, push, pop;

  // Writes are gated by credit as well, keeping req_ready a pure function of credit.
  assign req_ready = (credit_q != '0);
  assign req_fire  = req_valid & req_ready;
  assign rd_fire   = req_fire & ~|req_we;
  assign push      = lat_vld_q[READ_LATENCY-1];
  assign rsp_valid = (cnt_q != '0);
  assign pop       = rsp_valid & rsp_ready;
  assign rsp_rdata = rsp_valid ? fifo_mem_q[rd_ptr_q] : '0;

  assign ena    = ena_q;
  assign regcea = regcea_q;
  assign wea    = wea_q;
  assign addra  = addra_q;
  assign dina   = dina_q;

  always_comb begin
    ena_d    = req_fire;
    wea_d    = req_fire ? req_we : '0;
    addra_d  = req_fire ? req_addr : addra_q;
    dina_d   = req_fire ? req_wdata : dina_q;
    regcea_d = 1'b1;

    lat_vld_d    = '0;
    lat_vld_d[0] = ena_q & ~|wea_q;
    for (int i = 1; i < READ_LATENCY; i++) lat_vld_d[i] = lat_vld_q[i-1];

    credit_d = credit_q;
    if (rd_fire && !pop)      credit_d = credit_q - CNT_W'(1);
    else if (!rd_fire && pop) credit_d = credit_q + CNT_W'(1);

    cnt_d = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + CNT_W'(1);
    else if (!push && pop) cnt_d = cnt_q - CNT_W'(1);

    wr_ptr_d = wr_ptr_q;
    if (push) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
    rd_ptr_d = rd_ptr_q;
    if (pop)  rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
  end

  always_ff @(posedge clka) begin
    if (rsta) begin
      ena_q     <= 1'b0;
      regcea_q  <= 1'b0;
      wea_q     <= '0;
      addra_q   <= '0;
      dina_q    <= '0;
      lat_vld_q <= '0;
      credit_q  <= DEPTH_C;
      cnt_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
    end else begin
      ena_q     <= ena_d;
      regcea_q  <= regcea_d;
      wea_q     <= wea_d;
      addra_q   <= addra_d;
      dina_q    <= dina_d;
      lat_vld_q <= lat_vld_d;
      credit_q  <= credit_d;
      cnt_q     <= cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
    end
  end

  // Storage is data only; occupancy and pointers decide what is visible.
  always_ff @(posedge clka) begin
    if (push) fifo_mem_q[wr_ptr_q] <= douta;
  end

  always_ff @(posedge clka) begin
    if (!rsta) begin
      assert (!(push && !pop && cnt_q == DEPTH_C))
        else $error("response fifo overflow");
    end
  end

endmodule

// File: tb/tb_tdpram_port_master.sv
// Bench for tdpram_port_master: behavioural RAM, queue-based response model with
// due cycles, directed scenarios and a randomized phase.
module tb_tdpram_port_master;
  localparam int AW = 10, DW = 32, NB = 4, RL = 2, D = 4;

  logic          clka = 1'b0, rsta = 1'b1;
  logic          req_valid = 1'b0, rsp_ready = 1'b1;
  logic [NB-1:0] req_we = '0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          req_ready, rsp_valid, ena, regcea;
  logic [DW-1:0] rsp_rdata, dina, douta;
  logic [NB-1:0] wea;
  logic [AW-1:0] addra;

  int total = 0, bad = 0, pop_cnt = 0;

  tdpram_port_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_WRITE_WIDTH(8),
                       .READ_LATENCY(RL), .RSP_DEPTH(D)) dut (
    .clka(clka), .rsta(rsta), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .ena(ena), .regcea(regcea), .wea(wea), .addra(addra), .dina(dina), .douta(douta));

  always #5 clka = ~clka;

  function automatic logic [31:0] init_val(int i);
    return (32'(i) * 32'h9E3779B9) ^ 32'hA5A5_0000;
  endfunction

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Behavioural RAM: address registered on ena, output register gated by regcea.
  logic [DW-1:0] ram [0:1023];
  logic [DW-1:0] ram_s0;
  bit ram_init = 1'b0;
  always @(posedge clka) begin
    if (!ram_init) begin
      for (int i = 0; i < 1024; i++) ram[i] <= init_val(i);
      ram_init <= 1'b1;
    end else if (ena) begin
      ram_s0 <= ram[addra];
      for (int b = 0; b < NB; b++) if (wea[b]) ram[addra][8*b +: 8] <= dina[8*b +: 8];
    end
    if (regcea) douta <= ram_s0;
  end

  // Reference model: a read accepted in cycle T yields its data from cycle T+RL+2 on.
  typedef struct { logic [31:0] d; int due; } rsp_t;
  rsp_t q[$];
  logic [31:0] refmem [0:1023];
  bit model_init = 1'b0, live = 1'b0;
  int credit = D, cyc = 0;
  logic e_ena = 0, e_regcea = 0;
  logic [NB-1:0] e_wea = '0;
  logic [AW-1:0] e_addra = '0;
  logic [DW-1:0] e_dina = '0;

  always @(posedge clka) begin
    bit mv, fire;
    if (!model_init) begin
      for (int i = 0; i < 1024; i++) refmem[i] = init_val(i);
      model_init = 1'b1;
    end
    if (rsta) begin
      q.delete();
      credit = D; e_ena = 0; e_regcea = 0; e_wea = '0; e_addra = '0; e_dina = '0;
      live = 1'b1;
    end else begin
      mv   = (q.size() > 0) && (q[0].due <= cyc);
      fire = req_valid && (credit != 0);
      e_ena = fire;
      e_wea = fire ? req_we : '0;
      e_regcea = 1'b1;
      if (fire) begin e_addra = req_addr; e_dina = req_wdata; end
      if (fire && req_we == '0) begin
        q.push_back('{d: refmem[req_addr], due: cyc + RL + 2});
        credit--;
      end else if (fire) begin
        for (int b = 0; b < NB; b++) if (req_we[b]) refmem[req_addr][8*b +: 8] = req_wdata[8*b +: 8];
      end
      if (mv && rsp_ready) begin
        void'(q.pop_front());
        credit++;
      end
    end
    cyc++;
  end

  always @(negedge clka) begin
    bit ev;
    if (live) begin
      ev = (q.size() > 0) && (q[0].due <= cyc);
      chk("req_ready", req_ready, credit != 0);
      chk("ena", ena, e_ena);
      chk("wea", wea, e_wea);
      chk("addra", addra, e_addra);
      chk("dina", dina, e_dina);
      chk("regcea", regcea, e_regcea);
      chk("rsp_valid", rsp_valid, ev);
      if (ev) chk("rsp_rdata", rsp_rdata, q[0].d);
      if (rsp_valid && rsp_ready) pop_cnt++;
    end
  end

  task automatic step();
    @(posedge clka);
    #2;
  endtask

  task automatic send(input logic [NB-1:0] we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n;
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
    n = 0;
    while (!req_ready && n < 100) begin step(); n++; end
    if (n >= 100) chk("send_timeout", 0, 1);
    step();
  endtask

  initial begin
    int n, acc, p0, c;
    bit fired;
    // Reset held with a pending request.
    rsta = 1'b1; req_valid = 1'b1; req_addr = 10'd3;
    repeat (3) begin
      step();
      chk("t1_ena", ena, 0);
      chk("t1_wea", wea, 0);
      chk("t1_rsp_valid", rsp_valid, 0);
    end
    rsta = 1'b0; req_valid = 1'b0;
    chk("t1_ready_release", req_ready, 1);
    step();
    chk("t1_ready_after", req_ready, 1);

    // Full-word write then read-back, with exact latency.
    send(4'hF, 10'd5, 32'hDEADBEEF);
    send(4'h0, 10'd5, 32'h0);
    req_valid = 1'b0;
    step(); step();
    chk("t2_early", rsp_valid, 0);
    step();
    chk("t2_valid", rsp_valid, 1);
    chk("t2_data", rsp_rdata, 32'hDEADBEEF);

    // Byte-lane write merge.
    send(4'hF, 10'd7, 32'h11223344);
    send(4'b0010, 10'd7, 32'h0000AA00);
    send(4'h0, 10'd7, 32'h0);
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 50) begin step(); n++; end
    chk("t3_data", rsp_rdata, 32'h1122AA44);
    repeat (3) step();

    // Backpressure: only RSP_DEPTH reads can be outstanding.
    rsp_ready = 1'b0; acc = 0;
    for (int i = 0; i < 10; i++) begin
      req_valid = (acc < 6); req_we = '0; req_addr = AW'(acc);
      fired = req_valid && req_ready;
      step();
      if (fired) acc++;
    end
    chk("t4_accepted", acc, 4);
    chk("t4_ready_low", req_ready, 0);
    chk("t4_head_data", rsp_rdata, init_val(0));
    p0 = pop_cnt; rsp_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      req_valid = (acc < 6); req_addr = AW'(acc);
      fired = req_valid && req_ready;
      step();
      if (fired) acc++;
    end
    chk("t4_pops", pop_cnt - p0, 6);

    // Streaming reads.
    p0 = pop_cnt;
    for (int i = 0; i < 16; i++) send(4'h0, AW'($urandom_range(0, 1023)), 32'h0);
    req_valid = 1'b0;
    repeat (12) step();
    chk("t5_pops", pop_cnt - p0, 16);

    // Reset while reads are in flight.
    for (int i = 0; i < 3; i++) send(4'h0, AW'(i), 32'h0);
    req_valid = 1'b0; rsta = 1'b1;
    step();
    rsta = 1'b0;
    chk("t6_rsp_valid", rsp_valid, 0);
    chk("t6_ready", req_ready, 1);
    p0 = pop_cnt; c = 0;
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1; req_we = '0; req_addr = AW'(i + 10);
      if (req_ready) c++;
      step();
    end
    req_valid = 1'b0;
    chk("t6_b2b", c, 4);
    repeat (15) step();
    chk("t6_pops", pop_cnt - p0, 4);

    // Randomized traffic with occasional reset.
    for (int i = 0; i < 400; i++) begin
      rsta      = ($urandom_range(0, 99) == 0);
      req_valid = $urandom_range(0, 1) == 1;
      req_we    = ($urandom_range(0, 2) == 0) ? NB'($urandom) : '0;
      req_addr  = AW'($urandom_range(0, 15));
      req_wdata = $urandom;
      rsp_ready = $urandom_range(0, 3) != 0;
      step();
    end
    rsta = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
    repeat (20) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
